// File: rtl/std_mem_d1_copy.sv
// Sequential word copy engine: reads a source 1-D memory and writes a destination 1-D memory,
// one word per WRITE/WAIT pair, with a go/done handshake.
module std_mem_d1_copy #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SIZE     = 16,
    parameter int unsigned IDX_SIZE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic [IDX_SIZE-1:0] src_base,
    input  logic [IDX_SIZE-1:0] dst_base,
    input  logic [IDX_SIZE:0]   len,
    output logic [IDX_SIZE-1:0] src_addr0,
    input  logic [WIDTH-1:0]    src_read_data,
    output logic [IDX_SIZE-1:0] dst_addr0,
    output logic [WIDTH-1:0]    dst_write_data,
    output logic                dst_write_en,
    input  logic                dst_done,
    output logic                done,
    output logic [IDX_SIZE:0]   count
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWrite = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [IDX_SIZE:0] IdxOne = {{IDX_SIZE{1'b0}}, 1'b1};

    // A memory larger than its address space cannot be addressed at all.
    if (SIZE > (1 << IDX_SIZE)) begin : g_size_check
        $error("SIZE exceeds the address range of IDX_SIZE");
    end

    logic [1:0]          state_q, state_d;
    logic [IDX_SIZE:0]   idx_q, idx_d;
    logic [IDX_SIZE-1:0] src_base_q, src_base_d;
    logic [IDX_SIZE-1:0] dst_base_q, dst_base_d;
    logic [IDX_SIZE:0]   len_q, len_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [IDX_SIZE:0]   count_q, count_d;

    logic [IDX_SIZE-1:0] src_addr;
    logic [IDX_SIZE-1:0] dst_addr;
    logic [IDX_SIZE:0]   idx_inc;

    // Addresses wrap modulo 2^IDX_SIZE; the upper idx bit is dropped on purpose.
    assign src_addr = src_base_q + idx_q[IDX_SIZE-1:0];
    assign dst_addr = dst_base_q + idx_q[IDX_SIZE-1:0];
    assign idx_inc  = idx_q + IdxOne;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        src_base_d = src_base_q;
        dst_base_d = dst_base_q;
        len_d      = len_q;
        data_d     = data_q;
        count_d    = count_q;
        case (state_q)
            StIdle: begin
                if (go) begin
                    src_base_d = src_base;
                    dst_base_d = dst_base;
                    len_d      = len;
                    idx_d      = '0;
                    count_d    = '0;
                    state_d    = (len == '0) ? StDone : StWrite;
                end
            end
            StWrite: begin
                data_d  = src_read_data;
                state_d = StWait;
            end
            StWait: begin
                if (dst_done) begin
                    count_d = count_q + IdxOne;
                    if (idx_inc == len_q) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_inc;
                        state_d = StWrite;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    always_comb begin
        src_addr0      = '0;
        dst_addr0      = '0;
        dst_write_data = '0;
        dst_write_en   = 1'b0;
        done           = 1'b0;
        case (state_q)
            StWrite: begin
                src_addr0      = src_addr;
                dst_addr0      = dst_addr;
                dst_write_data = src_read_data;
                dst_write_en   = 1'b1;
            end
            StWait: begin
                src_addr0      = src_addr;
                dst_addr0      = dst_addr;
                dst_write_data = data_q;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign count = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            src_base_q <= '0;
            dst_base_q <= '0;
            len_q      <= '0;
            data_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            src_base_q <= src_base_d;
            dst_base_q <= dst_base_d;
            len_q      <= len_d;
            data_q     <= data_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_std_mem_d1_copy.sv
// Directed bench for std_mem_d1_copy with a combinational source memory and a
// std_mem_d1-style destination whose done pulse can be stretched on one word.
module tb_std_mem_d1_copy;

    localparam int unsigned W  = 32;
    localparam int unsigned IW = 4;
    localparam logic [31:0] Sentinel = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          go = 1'b0;
    logic [IW-1:0] src_base = '0;
    logic [IW-1:0] dst_base = '0;
    logic [IW:0]   len = '0;
    logic [IW-1:0] src_addr0;
    logic [W-1:0]  src_read_data;
    logic [IW-1:0] dst_addr0;
    logic [W-1:0]  dst_write_data;
    logic          dst_write_en;
    logic          dst_done;
    logic          done;
    logic [IW:0]   count;

    logic [W-1:0] smem [16];
    logic [W-1:0] dmem [16];
    int           wcnt = 0;
    int           stall_word = -1;

    int errors = 0;
    int checks = 0;

    logic [IW-1:0] s_src [64];
    logic [IW-1:0] s_dst [64];
    logic [W-1:0]  s_data [64];
    logic          s_we [64];
    logic [IW:0]   s_cnt [64];
    int            done_cyc;
    int            n_we;
    int            n_done;

    std_mem_d1_copy #(.WIDTH(W), .SIZE(16), .IDX_SIZE(IW)) dut (
        .clk            (clk),
        .reset          (reset),
        .go             (go),
        .src_base       (src_base),
        .dst_base       (dst_base),
        .len            (len),
        .src_addr0      (src_addr0),
        .src_read_data  (src_read_data),
        .dst_addr0      (dst_addr0),
        .dst_write_data (dst_write_data),
        .dst_write_en   (dst_write_en),
        .dst_done       (dst_done),
        .done           (done),
        .count          (count)
    );

    always #5 clk = ~clk;

    assign src_read_data = smem[src_addr0];
    assign dst_done      = (wcnt == 1);

    // Destination: write on the edge, done the next cycle (or two cycles later on the stalled word).
    always @(posedge clk) begin
        if (dst_write_en) begin
            dmem[dst_addr0] <= dst_write_data;
            wcnt <= (int'(count) == stall_word) ? 3 : 1;
        end else if (wcnt != 0) begin
            wcnt <= wcnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap(input int k);
        s_src[k]  = src_addr0;
        s_dst[k]  = dst_addr0;
        s_data[k] = dst_write_data;
        s_we[k]   = dst_write_en;
        s_cnt[k]  = count;
        if (dst_write_en) n_we++;
        if (done) n_done++;
    endtask

    // Cycle 0 is the IDLE cycle where go is sampled; snapshots are taken mid-cycle.
    task automatic run_copy(input logic [IW-1:0] sb, input logic [IW-1:0] db,
                            input logic [IW:0] ln, input int rst_at);
        done_cyc = -1;
        n_we     = 0;
        n_done   = 0;
        @(negedge clk);
        go       = 1'b1;
        src_base = sb;
        dst_base = db;
        len      = ln;
        snap(0);
        for (int k = 1; k < 60; k++) begin
            @(posedge clk);
            #1;
            go       = 1'b0;
            src_base = IW'($urandom);
            dst_base = IW'($urandom);
            len      = (IW + 1)'($urandom);
            @(negedge clk);
            if (k == rst_at) begin
                reset = 1'b0;
                #1;
                snap(k);
                break;
            end
            snap(k);
            if (done) begin
                done_cyc = k;
                break;
            end
        end
        @(negedge clk);
        if (done) n_done++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            smem[i] = 32'h100 + i;
            dmem[i] = Sentinel;
        end

        // Reset with random inputs
        #2;
        go       = 1'b1;
        src_base = 4'd7;
        dst_base = 4'd9;
        len      = 5'd3;
        reset    = 1'b0;
        #1;
        chk("rst_src_addr", 32'(src_addr0), 32'd0);
        chk("rst_dst_addr", 32'(dst_addr0), 32'd0);
        chk("rst_wdata", dst_write_data, 32'd0);
        chk("rst_we", 32'(dst_write_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        repeat (3) @(negedge clk);
        go = 1'b0;
        reset = 1'b1;
        n_we = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dst_write_en) n_we++;
        end
        chk("idle_no_we", 32'(n_we), 32'd0);

        // Basic copy
        smem[2] = 32'hA; smem[3] = 32'hB; smem[4] = 32'hC; smem[5] = 32'hD;
        run_copy(4'd2, 4'd8, 5'd4, -1);
        chk("basic_done_cyc", 32'(done_cyc), 32'd9);
        chk("basic_done_pulses", 32'(n_done), 32'd1);
        chk("basic_n_we", 32'(n_we), 32'd4);
        chk("basic_we1", 32'(s_we[1]), 32'd1);
        chk("basic_we2", 32'(s_we[2]), 32'd0);
        chk("basic_we3", 32'(s_we[3]), 32'd1);
        chk("basic_we5", 32'(s_we[5]), 32'd1);
        chk("basic_we7", 32'(s_we[7]), 32'd1);
        chk("basic_src1", 32'(s_src[1]), 32'd2);
        chk("basic_dst7", 32'(s_dst[7]), 32'd11);
        chk("basic_count", 32'(s_cnt[9]), 32'd4);
        chk("basic_dst8", dmem[8], 32'hA);
        chk("basic_dst9", dmem[9], 32'hB);
        chk("basic_dst10", dmem[10], 32'hC);
        chk("basic_dst11", dmem[11], 32'hD);
        chk("basic_dst12", dmem[12], Sentinel);
        chk("basic_count_hold", 32'(count), 32'd4);

        // Zero length
        run_copy(4'd3, 4'd5, 5'd0, -1);
        chk("zero_done_cyc", 32'(done_cyc), 32'd1);
        chk("zero_n_we", 32'(n_we), 32'd0);
        chk("zero_count", 32'(count), 32'd0);

        // Wrap around the address space
        smem[14] = 32'h1111_0001; smem[15] = 32'h1111_0002;
        smem[0]  = 32'h1111_0003; smem[1]  = 32'h1111_0004;
        run_copy(4'd14, 4'd15, 5'd4, -1);
        chk("wrap_done_cyc", 32'(done_cyc), 32'd9);
        chk("wrap_src1", 32'(s_src[1]), 32'd14);
        chk("wrap_src3", 32'(s_src[3]), 32'd15);
        chk("wrap_src5", 32'(s_src[5]), 32'd0);
        chk("wrap_src7", 32'(s_src[7]), 32'd1);
        chk("wrap_dst1", 32'(s_dst[1]), 32'd15);
        chk("wrap_dst3", 32'(s_dst[3]), 32'd0);
        chk("wrap_dst7", 32'(s_dst[7]), 32'd2);
        chk("wrap_d15", dmem[15], 32'h1111_0001);
        chk("wrap_d0", dmem[0], 32'h1111_0002);
        chk("wrap_d1", dmem[1], 32'h1111_0003);
        chk("wrap_d2", dmem[2], 32'h1111_0004);

        // Stall word 1 by two extra cycles
        for (int i = 8; i < 12; i++) dmem[i] = Sentinel;
        stall_word = 1;
        run_copy(4'd2, 4'd8, 5'd4, -1);
        stall_word = -1;
        chk("stall_done_cyc", 32'(done_cyc), 32'd11);
        chk("stall_n_we", 32'(n_we), 32'd4);
        for (int k = 4; k <= 6; k++) begin
            chk($sformatf("stall_we_c%0d", k), 32'(s_we[k]), 32'd0);
            chk($sformatf("stall_src_c%0d", k), 32'(s_src[k]), 32'd3);
            chk($sformatf("stall_dst_c%0d", k), 32'(s_dst[k]), 32'd9);
            chk($sformatf("stall_data_c%0d", k), s_data[k], 32'hB);
            chk($sformatf("stall_cnt_c%0d", k), 32'(s_cnt[k]), 32'd1);
        end
        chk("stall_cnt_c7", 32'(s_cnt[7]), 32'd2);
        chk("stall_we_c7", 32'(s_we[7]), 32'd1);
        chk("stall_we_c9", 32'(s_we[9]), 32'd1);
        chk("stall_count", 32'(s_cnt[11]), 32'd4);
        chk("stall_dst11", dmem[11], 32'hD);

        // Reset in cycle 4 of a four-word copy
        for (int i = 8; i < 12; i++) dmem[i] = Sentinel;
        run_copy(4'd2, 4'd8, 5'd4, 4);
        chk("mid_rst_src", 32'(s_src[4]), 32'd0);
        chk("mid_rst_dst", 32'(s_dst[4]), 32'd0);
        chk("mid_rst_data", s_data[4], 32'd0);
        chk("mid_rst_count", 32'(s_cnt[4]), 32'd0);
        chk("mid_rst_done", 32'(n_done), 32'd0);
        chk("mid_rst_d8", dmem[8], 32'hA);
        chk("mid_rst_d9", dmem[9], 32'hB);
        chk("mid_rst_d10", dmem[10], Sentinel);
        chk("mid_rst_d11", dmem[11], Sentinel);
        @(negedge clk);
        reset = 1'b1;
        run_copy(4'd2, 4'd8, 5'd4, -1);
        chk("fresh_done_cyc", 32'(done_cyc), 32'd9);
        chk("fresh_cnt_c2", 32'(s_cnt[2]), 32'd0);
        chk("fresh_cnt_c3", 32'(s_cnt[3]), 32'd1);
        chk("fresh_count", 32'(count), 32'd4);
        chk("fresh_d10", dmem[10], 32'hC);
        chk("fresh_d11", dmem[11], 32'hD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/std_mem_d1_copy.md
# std_mem_d1_copy

Sequential copy engine that moves `len` consecutive words from one single-ported 1-D memory into another. It drives the memory ports from the initiator side: the source read port (address out, read data in) and the destination write port (address, data, write enable out; done in). It sits inside generated components wherever a bulk memory-to-memory transfer is needed. It uses the same go/done handshake as other sequential primitives.

## Interface
Parameters:
- `WIDTH`, 32, data word width of both memories.
- `SIZE`, 16, number of words in each memory.
- `IDX_SIZE`, 4, address width of both memories.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `go`  in  1  start request; sampled only in IDLE.
- `src_base`  in  IDX_SIZE  first source address; latched on start.
- `dst_base`  in  IDX_SIZE  first destination address; latched on start.
- `len`  in  IDX_SIZE+1  number of words to copy; latched on start.
- `src_addr0`  out  IDX_SIZE  source memory address.
- `src_read_data`  in  WIDTH  source memory data; combinational read of `src_addr0`.
- `dst_addr0`  out  IDX_SIZE  destination memory address.
- `dst_write_data`  out  WIDTH  destination write data.
- `dst_write_en`  out  1  destination write enable.
- `dst_done`  in  1  destination write-complete pulse.
- `done`  out  1  one-cycle completion pulse.
- `count`  out  IDX_SIZE+1  number of words whose write has completed.

## Operation
- Registered state: FSM state, `idx`, latched `src_base`, `dst_base` and `len`, captured data word, `count`.
- The FSM has four states: IDLE, WRITE, WAIT, DONE.
- IDLE:
  - All handshake outputs are low.
  - When `go`=1, latch the bases and `len`, and clear `idx` and `count` to 0.
  - Next state is DONE if `len`=0, otherwise WRITE.
- WRITE (exactly one cycle):
  - `src_addr0` = `src_base`+`idx`.
  - `dst_addr0` = `dst_base`+`idx`.
  - `dst_write_data` = `src_read_data`, passed through combinationally. Capture it into the data register on the same edge.
  - `dst_write_en`=1.
  - Next state is WAIT.
- WAIT:
  - `dst_write_en`=0.
  - `src_addr0`, `dst_addr0` and `dst_write_data` (now from the capture register) hold the WRITE-cycle values.
  - Stay in WAIT until `dst_done`=1.
  - On `dst_done`=1, `count` increments. If `idx`+1 = `len`, go to DONE; otherwise `idx` increments and the next state is WRITE.
- DONE:
  - `done`=1 for exactly one cycle.
  - Next state is IDLE unconditionally.
  - If `go` is still high in the following IDLE cycle, a new copy starts. The parent must drop `go` on seeing `done`.
- Address arithmetic:
  - `base`+`idx` is computed modulo 2^IDX_SIZE, i.e. truncated to IDX_SIZE bits, so addresses wrap.
  - No bounds clamp is applied. Out-of-range addresses when SIZE < 2^IDX_SIZE are flagged by the memory, not by this block.
- `len` > SIZE is not rejected; the address sequence simply wraps.
- A `dst_done` seen outside WAIT is ignored.
- `go`, `src_base`, `dst_base` and `len` changing during a copy have no effect.
- `count` holds its final value after `done` until the next accepted `go`.
- Reset:
  - `reset`=0 forces IDLE immediately, regardless of `clk`.
  - All outputs go to 0 (`src_addr0`, `dst_addr0`, `dst_write_data`, `dst_write_en`, `done`, `count`), and `idx` goes to 0.
  - A write whose enable edge has already passed stays in memory. No further writes are issued.

## Timing
- Call the IDLE cycle in which `go`=1 is sampled cycle 0.
- Each word takes one WRITE cycle plus at least one WAIT cycle: 2 cycles per word when the destination asserts `dst_done` the cycle after the write.
- With `dst_done` returned the cycle after each write, `done` is high in cycle 2N+1 for `len`=N ≥ 1. For `len`=0, `done` is high in cycle 1.
- Each extra cycle `dst_done` is delayed adds one cycle to that word.
- `dst_write_en` is high for exactly one cycle per word, N pulses in total.
- The earliest next start is the IDLE cycle after DONE: a back-to-back copy has 1 idle cycle between `done` and the next WRITE.

## Test plan
- Reset: drive `reset`=0 mid-simulation with random inputs -> all outputs 0 and state IDLE within the same cycle. Release `reset` and keep `go`=0 -> no `dst_write_en` ever.
- Basic copy: WIDTH=32, src[2..5]=0xA,0xB,0xC,0xD, `src_base`=2, `dst_base`=8, `len`=4, `go` in cycle 0, destination model is a std_mem_d1 -> dst[8..11]=0xA..0xD, `dst_write_en` pulses in cycles 1,3,5,7, `done` high only in cycle 9, `count`=4.
- Zero length: `len`=0 -> `done` in cycle 1, no `dst_write_en`, `count`=0.
- Wrap: IDX_SIZE=4, `src_base`=14, `dst_base`=15, `len`=4 -> source addresses 14,15,0,1 and destination addresses 15,0,1,2, with data copied correctly.
- Stall: destination model delays `dst_done` by 3 cycles on word 1 -> addresses and data held stable and `dst_write_en` low throughout WAIT; `count` increments only on `dst_done`; total latency 9+2=11 cycles.
- Reset mid-copy: assert `reset`=0 in cycle 4 of the `len`=4 copy -> outputs 0 immediately, dst[8..9] written, dst[10..11] untouched. A new `go` afterwards performs a fresh full copy with `count` starting from 0.
